// File: rtl/apu_fir_tdm_sched.sv
// apu_fir_tdm_sched: time-multiplexes stereo I2S pairs onto one shared FIR and demultiplexes its output
//   AMCLK_i          audio master clock, rising edge
//   nARST            synchronous active-low reset
//   APDATA_*_i       stereo pair in (16-bit L/R, one-cycle valid strobe)
//   sink_*           FIR input stream (data, valid/sop/eop out, ready in); left beat = sop, right beat = eop
//   source_*_i       FIR output stream (24-bit data, valid/sop/eop)
//   APDATA_*_o       filtered L/R samples; APDATA_VALID_o = {left updated, right updated}
//   CLR_FLAGS_i      clears sticky flags; OVFL_o = pair dropped, SYNC_ERR_o = FIR output framing error
module apu_fir_tdm_sched #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        AMCLK_i,
    input  logic        nARST,
    input  logic [15:0] APDATA_LEFT_i,
    input  logic [15:0] APDATA_RIGHT_i,
    input  logic        APDATA_VALID_i,
    output logic [15:0] sink_data_o,
    output logic        sink_valid_o,
    output logic        sink_sop_o,
    output logic        sink_eop_o,
    input  logic        sink_ready_i,
    input  logic [23:0] source_data_i,
    input  logic        source_valid_i,
    input  logic        source_sop_i,
    input  logic        source_eop_i,
    output logic [23:0] APDATA_LEFT_o,
    output logic [23:0] APDATA_RIGHT_o,
    output logic [1:0]  APDATA_VALID_o,
    input  logic        CLR_FLAGS_i,
    output logic        OVFL_o,
    output logic        SYNC_ERR_o
);
    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R, GAP} state_t;

    // Counter is preloaded with one less so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] buf_l, buf_r, cur_r;
    logic        buf_full, exp_right;
    logic [3:0]  gap_cnt;
    logic        dispatch, load_direct, store, drop;
    logic        src_left, src_right, src_err;

    always_ff @(posedge AMCLK_i) begin
        if (!nARST) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        dispatch    = 1'b0;
        load_direct = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    state_nxt = SEND_L;
                    dispatch  = 1'b1;
                end else if (APDATA_VALID_i) begin
                    state_nxt   = SEND_L;
                    load_direct = 1'b1;
                end
            end
            SEND_L: if (sink_ready_i) state_nxt = SEND_R;
            SEND_R: if (sink_ready_i) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:    if (gap_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A dispatching buffer frees its slot in the same cycle, so a new strobe can refill it.
        store = APDATA_VALID_i && !load_direct && (!buf_full || dispatch);
        drop  = APDATA_VALID_i && !load_direct && buf_full && !dispatch;
    end

    assign src_left  = source_valid_i && source_sop_i && !source_eop_i;
    assign src_right = source_valid_i && source_eop_i && !source_sop_i && exp_right;
    assign src_err   = source_valid_i && (!(src_left || src_right) || (src_left && exp_right));

    always_ff @(posedge AMCLK_i) begin
        if (!nARST) begin
            buf_l          <= '0;
            buf_r          <= '0;
            cur_r          <= '0;
            buf_full       <= 1'b0;
            gap_cnt        <= '0;
            sink_data_o    <= '0;
            sink_valid_o   <= 1'b0;
            sink_sop_o     <= 1'b0;
            sink_eop_o     <= 1'b0;
            exp_right      <= 1'b0;
            APDATA_LEFT_o  <= '0;
            APDATA_RIGHT_o <= '0;
            APDATA_VALID_o <= '0;
            OVFL_o         <= 1'b0;
            SYNC_ERR_o     <= 1'b0;
        end else begin
            if (dispatch || load_direct) begin
                sink_data_o <= dispatch ? buf_l : APDATA_LEFT_i;
                cur_r       <= dispatch ? buf_r : APDATA_RIGHT_i;
            end else if (state == SEND_L && sink_ready_i) begin
                sink_data_o <= cur_r;
            end
            sink_valid_o <= (state_nxt == SEND_L) || (state_nxt == SEND_R);
            sink_sop_o   <= state_nxt == SEND_L;
            sink_eop_o   <= state_nxt == SEND_R;
            if (store) begin
                buf_l <= APDATA_LEFT_i;
                buf_r <= APDATA_RIGHT_i;
            end
            buf_full <= store || (buf_full && !dispatch);
            gap_cnt  <= (state_nxt == GAP && state != GAP) ? GAP_LOAD :
                        (state == GAP && gap_cnt != 4'd0) ? gap_cnt - 4'd1 : gap_cnt;
            if (src_left)  APDATA_LEFT_o  <= source_data_i;
            if (src_right) APDATA_RIGHT_o <= source_data_i;
            APDATA_VALID_o <= {src_left, src_right};
            exp_right      <= src_left || (exp_right && !src_right);
            // Set terms are OR-ed after the clear so a same-cycle event wins.
            OVFL_o     <= drop || (OVFL_o && !CLR_FLAGS_i);
            SYNC_ERR_o <= src_err || (SYNC_ERR_o && !CLR_FLAGS_i);
        end
    end
endmodule

// File: tb/tb_apu_fir_tdm_sched.sv
// tb_apu_fir_tdm_sched: transaction model plus directed vectors for apu_fir_tdm_sched
module tb_apu_fir_tdm_sched;
    localparam int GAP = 1;

    logic        AMCLK_i = 1'b0;
    logic        nARST;
    logic [15:0] APDATA_LEFT_i, APDATA_RIGHT_i;
    logic        APDATA_VALID_i;
    logic [15:0] sink_data_o;
    logic        sink_valid_o, sink_sop_o, sink_eop_o, sink_ready_i;
    logic [23:0] source_data_i;
    logic        source_valid_i, source_sop_i, source_eop_i;
    logic [23:0] APDATA_LEFT_o, APDATA_RIGHT_o;
    logic [1:0]  APDATA_VALID_o;
    logic        CLR_FLAGS_i, OVFL_o, SYNC_ERR_o;

    apu_fir_tdm_sched #(.GAP_CYCLES(GAP)) dut (
        .AMCLK_i(AMCLK_i), .nARST(nARST),
        .APDATA_LEFT_i(APDATA_LEFT_i), .APDATA_RIGHT_i(APDATA_RIGHT_i), .APDATA_VALID_i(APDATA_VALID_i),
        .sink_data_o(sink_data_o), .sink_valid_o(sink_valid_o), .sink_sop_o(sink_sop_o),
        .sink_eop_o(sink_eop_o), .sink_ready_i(sink_ready_i),
        .source_data_i(source_data_i), .source_valid_i(source_valid_i),
        .source_sop_i(source_sop_i), .source_eop_i(source_eop_i),
        .APDATA_LEFT_o(APDATA_LEFT_o), .APDATA_RIGHT_o(APDATA_RIGHT_o), .APDATA_VALID_o(APDATA_VALID_o),
        .CLR_FLAGS_i(CLR_FLAGS_i), .OVFL_o(OVFL_o), .SYNC_ERR_o(SYNC_ERR_o)
    );

    always #5 AMCLK_i = ~AMCLK_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = free, 1 = left beat offered, 2 = right beat offered, 3 = gap.
    int          m_phase, m_gap;
    bit          m_started = 0;
    logic        m_bufv, m_exp, ov, se;
    logic [15:0] m_bl, m_br, m_cr;
    logic        e_valid, e_sop, e_eop, e_ovfl, e_sync;
    logic [15:0] e_data;
    logic [23:0] e_left, e_right;
    logic [1:0]  e_vout;

    always @(posedge AMCLK_i) begin
        m_started = 1;
        if (!nARST) begin
            m_phase = 0; m_gap = 0; m_bufv = 0; m_exp = 0;
            m_bl = 0; m_br = 0; m_cr = 0;
            e_data = 0; e_ovfl = 0; e_sync = 0; e_left = 0; e_right = 0; e_vout = 0;
        end else begin
            ov = 0;
            se = 0;
            if (m_phase == 0) begin
                if (m_bufv) begin
                    m_phase = 1; e_data = m_bl; m_cr = m_br;
                    m_bufv = APDATA_VALID_i;
                    if (APDATA_VALID_i) begin m_bl = APDATA_LEFT_i; m_br = APDATA_RIGHT_i; end
                end else if (APDATA_VALID_i) begin
                    m_phase = 1; e_data = APDATA_LEFT_i; m_cr = APDATA_RIGHT_i;
                end
            end else begin
                if (APDATA_VALID_i) begin
                    if (m_bufv) ov = 1;
                    else begin m_bufv = 1; m_bl = APDATA_LEFT_i; m_br = APDATA_RIGHT_i; end
                end
                if (m_phase == 1 && sink_ready_i) begin
                    m_phase = 2; e_data = m_cr;
                end else if (m_phase == 2 && sink_ready_i) begin
                    m_phase = (GAP == 0) ? 0 : 3; m_gap = GAP;
                end else if (m_phase == 3) begin
                    m_gap--;
                    if (m_gap == 0) m_phase = 0;
                end
            end
            e_vout = 2'b00;
            if (source_valid_i) begin
                if (source_sop_i && !source_eop_i) begin
                    e_left = source_data_i; e_vout = 2'b10;
                    if (m_exp) se = 1;
                    m_exp = 1;
                end else if (source_eop_i && !source_sop_i && m_exp) begin
                    e_right = source_data_i; e_vout = 2'b01; m_exp = 0;
                end else se = 1;
            end
            e_ovfl = ov | (e_ovfl & ~CLR_FLAGS_i);
            e_sync = se | (e_sync & ~CLR_FLAGS_i);
        end
        e_valid = (m_phase == 1) || (m_phase == 2);
        e_sop   = m_phase == 1;
        e_eop   = m_phase == 2;
    end

    always @(negedge AMCLK_i) begin
        if (m_started) begin
            chk("sink_valid", 32'(sink_valid_o), 32'(e_valid));
            chk("sink_sop", 32'(sink_sop_o), 32'(e_sop));
            chk("sink_eop", 32'(sink_eop_o), 32'(e_eop));
            if (e_valid) chk("sink_data", 32'(sink_data_o), 32'(e_data));
            chk("sop_eop_excl", 32'(sink_sop_o & sink_eop_o), 32'd0);
            chk("left_o", 32'(APDATA_LEFT_o), 32'(e_left));
            chk("right_o", 32'(APDATA_RIGHT_o), 32'(e_right));
            chk("valid_o", 32'(APDATA_VALID_o), 32'(e_vout));
            chk("ovfl", 32'(OVFL_o), 32'(e_ovfl));
            chk("sync_err", 32'(SYNC_ERR_o), 32'(e_sync));
        end
    end

    task automatic tick();
        @(posedge AMCLK_i);
        #1;
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        APDATA_LEFT_i = l; APDATA_RIGHT_i = r; APDATA_VALID_i = 1;
        tick();
        APDATA_VALID_i = 0;
    endtask

    task automatic src(input logic [23:0] d, input logic s, input logic e);
        source_data_i = d; source_sop_i = s; source_eop_i = e; source_valid_i = 1;
        tick();
        source_valid_i = 0; source_sop_i = 0; source_eop_i = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_zero_sink"}, 32'({sink_valid_o, sink_sop_o, sink_eop_o, sink_data_o}), 32'd0);
        chk({tag, "_zero_left"}, 32'(APDATA_LEFT_o), 32'd0);
        chk({tag, "_zero_right"}, 32'(APDATA_RIGHT_o), 32'd0);
        chk({tag, "_zero_flags"}, 32'({APDATA_VALID_o, OVFL_o, SYNC_ERR_o}), 32'd0);
    endtask

    initial begin
        nARST = 0; sink_ready_i = 1; CLR_FLAGS_i = 1;
        APDATA_LEFT_i = 16'h5555; APDATA_RIGHT_i = 16'hAAAA; APDATA_VALID_i = 1;
        source_data_i = 24'h123456; source_valid_i = 1; source_sop_i = 1; source_eop_i = 0;
        repeat (3) tick();
        chk_all_zero("reset");
        nARST = 1; CLR_FLAGS_i = 0; APDATA_VALID_i = 0;
        source_valid_i = 0; source_sop_i = 0;
        repeat (2) tick();

        // Minimum latency pair
        strobe(16'h1234, 16'hABCD);
        chk("lat_left", 32'({sink_valid_o, sink_sop_o, sink_eop_o, sink_data_o}), 32'h0006_1234);
        tick();
        chk("lat_right", 32'({sink_valid_o, sink_sop_o, sink_eop_o, sink_data_o}), 32'h0005_ABCD);
        tick();
        chk("lat_idle", 32'(sink_valid_o), 32'd0);
        repeat (3) tick();

        // Stall during left beat
        sink_ready_i = 0;
        strobe(16'h0F0F, 16'hF0F0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_left", 32'({sink_valid_o, sink_sop_o, sink_eop_o, sink_data_o}), 32'h0006_0F0F);
            tick();
        end
        sink_ready_i = 1;
        tick();
        chk("stall_right", 32'({sink_valid_o, sink_sop_o, sink_eop_o, sink_data_o}), 32'h0005_F0F0);
        tick();
        repeat (3) tick();

        // Buffer one pair, drop the third
        sink_ready_i = 0;
        strobe(16'h1111, 16'h2222);
        strobe(16'h3333, 16'h4444);
        strobe(16'h5555, 16'h6666);
        chk("ovfl_set", 32'(OVFL_o), 32'd1);
        sink_ready_i = 1;
        repeat (4) tick();
        chk("buffered_left", 32'({sink_sop_o, sink_data_o}), 32'h0001_3333);
        tick();
        chk("buffered_right", 32'({sink_eop_o, sink_data_o}), 32'h0001_4444);
        tick();
        chk("ovfl_held", 32'(OVFL_o), 32'd1);
        CLR_FLAGS_i = 1;
        tick();
        CLR_FLAGS_i = 0;
        chk("ovfl_clr", 32'(OVFL_o), 32'd0);

        // Drop coinciding with clear: set wins
        sink_ready_i = 0;
        strobe(16'h7777, 16'h8888);
        strobe(16'h9999, 16'hAAAA);
        CLR_FLAGS_i = 1;
        strobe(16'hBBBB, 16'hCCCC);
        CLR_FLAGS_i = 0;
        chk("ovfl_set_wins", 32'(OVFL_o), 32'd1);
        CLR_FLAGS_i = 1;
        tick();
        CLR_FLAGS_i = 0;
        chk("ovfl_clr2", 32'(OVFL_o), 32'd0);
        sink_ready_i = 1;
        repeat (10) tick();

        // Demux side
        src(24'h00FF00, 1, 0);
        chk("demux_left", 32'({APDATA_VALID_o, APDATA_LEFT_o}), 32'h0200_FF00);
        src(24'h000100, 0, 1);
        chk("demux_right", 32'({APDATA_VALID_o, APDATA_RIGHT_o}), 32'h0100_0100);
        tick();
        chk("demux_pulse_end", 32'(APDATA_VALID_o), 32'd0);
        src(24'h777777, 0, 1);
        chk("orphan_eop", 32'({SYNC_ERR_o, APDATA_VALID_o, APDATA_RIGHT_o}), 32'h0400_0100);
        CLR_FLAGS_i = 1;
        tick();
        CLR_FLAGS_i = 0;
        chk("sync_clr", 32'(SYNC_ERR_o), 32'd0);
        src(24'hFFFFFF, 1, 0);
        src(24'h800000, 1, 0);
        chk("double_sop", 32'({SYNC_ERR_o, APDATA_LEFT_o}), 32'h0180_0000);
        src(24'h111111, 1, 1);
        src(24'h222222, 0, 0);
        src(24'h7FFFFF, 0, 1);
        chk("resync_right", 32'({APDATA_VALID_o, APDATA_RIGHT_o}), 32'h017F_FFFF);
        repeat (2) tick();

        // Reset during right beat, with a pair buffered
        sink_ready_i = 0;
        strobe(16'hDEAD, 16'hBEEF);
        strobe(16'hCAFE, 16'hF00D);
        sink_ready_i = 1;
        tick();
        chk("pre_reset_right", 32'({sink_eop_o, sink_data_o}), 32'h0001_BEEF);
        nARST = 0; APDATA_VALID_i = 1; source_valid_i = 1; source_sop_i = 1;
        tick();
        chk_all_zero("mid_reset");
        nARST = 1; APDATA_VALID_i = 0; source_valid_i = 0; source_sop_i = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_beat", 32'(sink_valid_o), 32'd0);
        end
        strobe(16'h4321, 16'h8765);
        chk("post_reset_left", 32'({sink_valid_o, sink_sop_o, sink_eop_o, sink_data_o}), 32'h0006_4321);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apu_fir_tdm_sched.md
APU_FIR_TDM_SCHED -- requirements
Module: apu_fir_tdm_sched

Interface
REQ-001 Parameter: GAP_CYCLES, default 1 (range 0..15), idle cycles forced after each right-channel transfer before the next left transfer.
REQ-002 The clock port SHALL be: AMCLK_i  in  1  audio master clock; all logic SHALL run on its rising edge.
REQ-003 The reset port SHALL be: nARST  in  1  reset, synchronous and active-low.
REQ-004 APDATA_LEFT_i  in  16  left sample from the I2S receiver.
REQ-005 APDATA_RIGHT_i  in  16  right sample, qualified with the left sample.
REQ-006 APDATA_VALID_i  in  1  one-cycle strobe marking a new stereo pair.
REQ-007 sink_data_o  out  16  sample to the shared FIR.
REQ-008 sink_valid_o / sink_sop_o / sink_eop_o  out  1 each  FIR input qualifiers.
REQ-009 sink_ready_i  in  1  FIR accepts the beat when sink_valid_o and sink_ready_i are both high.
REQ-010 source_data_i  in  24  filtered sample from the FIR.
REQ-011 source_valid_i / source_sop_i / source_eop_i  in  1 each  FIR output qualifiers; sop marks left, eop marks right.
REQ-012 APDATA_LEFT_o / APDATA_RIGHT_o  out  24 each  demultiplexed filtered samples.
REQ-013 APDATA_VALID_o  out  2  bit1 = left updated, bit0 = right updated; one-cycle pulses.
REQ-014 CLR_FLAGS_i  in  1  clears the sticky flags.
REQ-015 OVFL_o  out  1  sticky: an input pair was dropped.
REQ-016 SYNC_ERR_o  out  1  sticky: the FIR output framing was violated.

Function
REQ-017 Pending store: one-deep stereo buffer (buf_l, buf_r, buf_full).
REQ-018 FSM states: IDLE, SEND_L, SEND_R, GAP.
REQ-019 In IDLE with buf_full=0 and APDATA_VALID_i=1, the FSM SHALL go to SEND_L, load the pair directly, and assert sink_valid_o=1, sink_sop_o=1, sink_eop_o=0 with sink_data_o=left on the next cycle.
REQ-020 In IDLE with buf_full=1, the FSM SHALL dispatch the buffer to SEND_L and clear buf_full; an APDATA_VALID_i in the same cycle SHALL be stored into the buffer.
REQ-021 When APDATA_VALID_i arrives in any other state, the pair SHALL be stored if buf_full=0; if buf_full=1, the new pair SHALL be dropped, the buffer kept, and OVFL_o set.
REQ-022 SEND_L SHALL hold its outputs stable until accepted, then go to SEND_R: sink_data_o=right, sink_sop_o=0, sink_eop_o=1.
REQ-023 SEND_R SHALL hold its outputs until accepted, then deassert sink_valid_o, sink_sop_o and sink_eop_o, and go to GAP (or to IDLE if GAP_CYCLES=0).
REQ-024 GAP SHALL count down GAP_CYCLES cycles with sink_valid_o=0, then go to IDLE.
REQ-025 sink_sop_o and sink_eop_o SHALL be 0 whenever sink_valid_o=0 and SHALL never both be 1.
REQ-026 Minimum latency: APDATA_VALID_i at cycle t -> left beat valid at t+1 -> right beat valid at t+2, given sink_ready_i=1.
REQ-027 Demux tracking: an exp_right flag SHALL be set by an accepted left beat and cleared by an accepted right beat.
REQ-028 On source_valid_i with sop=1, eop=0: APDATA_LEFT_o SHALL load source_data_i, APDATA_VALID_o[1] SHALL pulse on the next cycle, and exp_right SHALL be set; if exp_right was already 1, SYNC_ERR_o SHALL also be set.
REQ-029 On source_valid_i with eop=1, sop=0 and exp_right=1: APDATA_RIGHT_o SHALL load, APDATA_VALID_o[0] SHALL pulse on the next cycle, and exp_right SHALL be cleared.
REQ-030 On source_valid_i with eop=1 and exp_right=0, with sop=eop=1, or with sop=eop=0: the data SHALL be discarded, SYNC_ERR_o set, and the outputs unchanged.
REQ-031 The data outputs SHALL hold their last value between updates; the sample is passed through at 24 bits, with no rounding or saturation.
REQ-032 CLR_FLAGS_i SHALL clear OVFL_o and SYNC_ERR_o on the next cycle; a set event in the same cycle SHALL win over the clear.

Reset
REQ-033 nARST=0 at a clock edge SHALL force: state IDLE, buf_full=0, exp_right=0, GAP counter 0, every output 0 (data, valid, sop, eop, APDATA_VALID_o, flags).
REQ-034 Reset mid-transfer SHALL abandon the in-flight pair and the buffered pair; the first beat after release SHALL be a left beat with sop=1.
REQ-035 Inputs SHALL be ignored while nARST=0.

Verification
REQ-036 Pair L=0x1234, R=0xABCD with sink_ready_i=1 -> cycle t+1 beat 0x1234 sop=1; t+2 beat 0xABCD eop=1; t+3 sink_valid_o=0.
REQ-037 sink_ready_i held low 5 cycles during SEND_L -> beat and sop stable all 5 cycles; right beat follows 1 cycle after ready rises.
REQ-038 Three strobes during one stalled transfer -> 2nd buffered and sent next; 3rd dropped; OVFL_o=1 until CLR_FLAGS_i.
REQ-039 Source left 0x00FF00 then right 0x000100 -> APDATA_LEFT_o=0x00FF00 with VALID_o=10, then APDATA_RIGHT_o=0x000100 with VALID_o=01.
REQ-040 Source eop without preceding sop -> APDATA_RIGHT_o unchanged, SYNC_ERR_o=1; CLR_FLAGS_i clears it the next cycle.
REQ-041 nARST=0 asserted in SEND_R -> all outputs 0 next cycle; a new strobe after release yields sop=1 on the left sample.
